// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline sequencer: state encoding, buffer bit
// order and the RUN-state branch/load-use decode shared by RUN and MEM_WAIT.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Bit order of the bundled go/clear vectors
  localparam int unsigned N_BUF       = 4;
  localparam int unsigned BUF_IF_ID   = 0;
  localparam int unsigned BUF_ID_EXE  = 1;
  localparam int unsigned BUF_EXE_MEM = 2;
  localparam int unsigned BUF_MEM_WB  = 3;

  typedef struct packed {
    logic             pc_en;
    logic [N_BUF-1:0] go;
    logic [N_BUF-1:0] clr;
    logic             stall;
    logic             flush;
  } ctrl_t;

  // Advance decode: a taken branch squashes the wrong-path ID instruction,
  // otherwise a load-use hazard holds IF/ID and injects a bubble into ID_EXE.
  function automatic ctrl_t run_decode(input logic branch, input logic load_use);
    ctrl_t c;
    c       = '0;
    c.go    = '1;
    c.pc_en = 1'b1;
    if (branch) begin
      c.clr[BUF_IF_ID]  = 1'b1;
      c.clr[BUF_ID_EXE] = 1'b1;
      c.flush           = 1'b1;
    end else if (load_use) begin
      c.pc_en           = 1'b0;
      c.go[BUF_IF_ID]   = 1'b0;
      c.clr[BUF_ID_EXE] = 1'b1;
      c.stall           = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare between the ID sources and the EXE load destination.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic [4:0] exe_rd,
  input  logic       exe_mem_read,
  output logic       load_use_c
);

  assign load_use_c = exe_mem_read && (exe_rd != REG_ZERO) &&
                      ((id_uses_rs && (id_rs == exe_rd)) ||
                       (id_uses_rt && (id_rt == exe_rd)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: buffer go/clear and PC enable generation, memory wait
// and halt handling, plus saturating debug counters.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [4:0]       exe_rd,
  input  logic             exe_mem_read,
  input  logic             exe_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             wb_halt,
  input  logic             resume,
  output logic             pc_en,
  output logic             go_if_id,
  output logic             clear_if_id,
  output logic             go_id_exe,
  output logic             clear_id_exe,
  output logic             go_exe_mem,
  output logic             clear_exe_mem,
  output logic             go_mem_wb,
  output logic             clear_mem_wb,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int unsigned WAIT_W = 8;

  state_t            state, next_state;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              armed;
  logic              load_use_c;
  logic              err_set_c;
  logic              halt_take_c;
  ctrl_t             ctrl_c;

  hazard_detect u_hazard (
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .exe_rd       (exe_rd),
    .exe_mem_read (exe_mem_read),
    .load_use_c   (load_use_c)
  );

  // Next-state and control decode
  always_comb begin
    ctrl_c      = '0;
    next_state  = state;
    wait_nxt    = wait_cnt;
    err_set_c   = 1'b0;
    halt_take_c = 1'b0;
    case (state)
      ST_RUN: begin
        if (wb_halt && armed) begin
          ctrl_c.go[BUF_MEM_WB] = 1'b1;
          halt_take_c           = 1'b1;
          next_state            = ST_HALT;
        end else if (mem_req && !mem_ready) begin
          wait_nxt   = WAIT_W'(1);
          next_state = ST_MEM_WAIT;
        end else begin
          ctrl_c = run_decode(exe_branch_taken, load_use_c);
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          ctrl_c     = run_decode(exe_branch_taken, load_use_c);
          next_state = ST_RUN;
        end else if (wait_cnt >= WAIT_W'(MEM_TIMEOUT)) begin
          err_set_c  = 1'b1;
          next_state = ST_HALT;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
        ctrl_c.stall = 1'b1;
      end
      ST_HALT: begin
        if (resume) next_state = ST_RUN;
      end
      default: next_state = ST_RUN;
    endcase
  end

  // State, flags and saturating counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      wait_cnt  <= '0;
      armed     <= 1'b1;
      halted    <= 1'b0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      cycle_cnt <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= wait_nxt;
      halted   <= (next_state == ST_HALT);
      // A held wb_halt must drop for a cycle before it can halt again
      if (halt_take_c) armed <= 1'b0;
      else if (!wb_halt) armed <= 1'b1;
      if (err_set_c) mem_err <= 1'b1;
      else if ((state == ST_HALT) && resume) mem_err <= 1'b0;
      if (ctrl_c.stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (ctrl_c.flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
      if ((state != ST_HALT) && (cycle_cnt != '1)) cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

  // Controls are forced low while reset is held
  assign pc_en         = rst_n & ctrl_c.pc_en;
  assign go_if_id      = rst_n & ctrl_c.go[BUF_IF_ID];
  assign go_id_exe     = rst_n & ctrl_c.go[BUF_ID_EXE];
  assign go_exe_mem    = rst_n & ctrl_c.go[BUF_EXE_MEM];
  assign go_mem_wb     = rst_n & ctrl_c.go[BUF_MEM_WB];
  assign clear_if_id   = rst_n & ctrl_c.clr[BUF_IF_ID];
  assign clear_id_exe  = rst_n & ctrl_c.clr[BUF_ID_EXE];
  assign clear_exe_mem = rst_n & ctrl_c.clr[BUF_EXE_MEM];
  assign clear_mem_wb  = rst_n & ctrl_c.clr[BUF_MEM_WB];

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: decode table in RUN plus hand sequences
// for memory wait, timeout, halt/resume and asynchronous reset.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs, id_rt, exe_rd;
  logic        id_uses_rs, id_uses_rt, exe_mem_read, exe_branch_taken;
  logic        mem_req, mem_ready, wb_halt, resume;
  logic        pc_en, go_if_id, clear_if_id, go_id_exe, clear_id_exe;
  logic        go_exe_mem, clear_exe_mem, go_mem_wb, clear_mem_wb;
  logic        halted, mem_err;
  logic [31:0] stall_cnt, flush_cnt, cycle_cnt;

  pipeline_ctrl #(.CNT_W(32), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .exe_rd(exe_rd), .exe_mem_read(exe_mem_read), .exe_branch_taken(exe_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .wb_halt(wb_halt), .resume(resume),
    .pc_en(pc_en),
    .go_if_id(go_if_id), .clear_if_id(clear_if_id),
    .go_id_exe(go_id_exe), .clear_id_exe(clear_id_exe),
    .go_exe_mem(go_exe_mem), .clear_exe_mem(clear_exe_mem),
    .go_mem_wb(go_mem_wb), .clear_mem_wb(clear_mem_wb),
    .halted(halted), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  // {pc_en, go if/id/exe/mem, clear if/id/exe/mem}
  localparam logic [8:0] CT_NORMAL = 9'b1_1111_0000;
  localparam logic [8:0] CT_BRANCH = 9'b1_1111_1100;
  localparam logic [8:0] CT_LU     = 9'b0_0111_0100;
  localparam logic [8:0] CT_FREEZE = 9'b0_0000_0000;
  localparam logic [8:0] CT_HALTGO = 9'b0_0001_0000;

  typedef struct {
    logic [4:0] rs, rt;
    logic       urs, urt;
    logic [4:0] rd;
    logic       mrd, br;
    logic [8:0] ctrl;
    logic       sd, fd;
  } vec_t;

  vec_t        vecs[9];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_stall, exp_flush, exp_cyc;

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                              input logic urt, input logic [4:0] rd, input logic mrd,
                              input logic br, input logic [8:0] ctrl, input logic sd,
                              input logic fd);
    vec_t v;
    v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.rd = rd;
    v.mrd = mrd; v.br = br; v.ctrl = ctrl; v.sd = sd; v.fd = fd;
    return v;
  endfunction

  function automatic logic [8:0] ctrl_now();
    return {pc_en, go_if_id, go_id_exe, go_exe_mem, go_mem_wb,
            clear_if_id, clear_id_exe, clear_exe_mem, clear_mem_wb};
  endfunction

  task automatic chk_ctrl(input string name, input logic [8:0] exp);
    total++;
    if (ctrl_now() !== exp) begin
      bad++;
      $display("FAIL %s: ctrl got %b want %b", name, ctrl_now(), exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
    chk_val({tag, "_stall"}, stall_cnt, exp_stall);
    chk_val({tag, "_flush"}, flush_cnt, exp_flush);
    chk_val({tag, "_cycle"}, cycle_cnt, exp_cyc);
  endtask

  // One clock; cycle_cnt is expected to advance unless the cycle is spent in HALT
  task automatic step(input bit halt_cyc);
    @(posedge clk);
    if (!halt_cyc) exp_cyc++;
    #1;
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    exe_rd = '0; exe_mem_read = 1'b0; exe_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; wb_halt = 1'b0; resume = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vecs[0] = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, CT_NORMAL, 0, 0);
    vecs[1] = mk(5'd8, 5'd0, 1, 0, 5'd8, 1, 0, CT_LU,     1, 0);
    vecs[2] = mk(5'd0, 5'd0, 1, 0, 5'd0, 1, 0, CT_NORMAL, 0, 0);
    vecs[3] = mk(5'd3, 5'd9, 0, 1, 5'd9, 1, 0, CT_LU,     1, 0);
    vecs[4] = mk(5'd8, 5'd0, 0, 0, 5'd8, 1, 0, CT_NORMAL, 0, 0);
    vecs[5] = mk(5'd8, 5'd0, 1, 0, 5'd8, 0, 0, CT_NORMAL, 0, 0);
    vecs[6] = mk(5'd8, 5'd0, 1, 0, 5'd8, 1, 1, CT_BRANCH, 0, 1);
    vecs[7] = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, CT_BRANCH, 0, 1);
    vecs[8] = mk(5'd4, 5'd5, 1, 1, 5'd5, 1, 0, CT_LU,     1, 0);

    idle();
    rst_n = 1'b0;
    exp_stall = '0; exp_flush = '0; exp_cyc = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_ctrl("reset_ctrl", CT_FREEZE);
    chk_bit("reset_halted", halted, 1'b0);
    chk_bit("reset_mem_err", mem_err, 1'b0);
    chk_cnt("reset");
    rst_n = 1'b1;

    // Decode table in RUN
    for (int i = 0; i < 9; i++) begin
      id_rs = vecs[i].rs; id_rt = vecs[i].rt;
      id_uses_rs = vecs[i].urs; id_uses_rt = vecs[i].urt;
      exe_rd = vecs[i].rd; exe_mem_read = vecs[i].mrd; exe_branch_taken = vecs[i].br;
      @(negedge clk);
      chk_ctrl($sformatf("vec%0d_ctrl", i), vecs[i].ctrl);
      step(0);
      exp_stall += 32'(vecs[i].sd);
      exp_flush += 32'(vecs[i].fd);
      chk_cnt($sformatf("vec%0d", i));
    end
    idle();

    // Memory wait with completion after three frozen cycles
    mem_req = 1'b1;
    @(negedge clk);
    chk_ctrl("mw_run_freeze", CT_FREEZE);
    step(0);
    chk_bit("mw_not_halted", halted, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_ctrl($sformatf("mw_wait%0d", i), CT_FREEZE);
      step(0);
      exp_stall++;
    end
    mem_ready = 1'b1;
    @(negedge clk);
    chk_ctrl("mw_done_ctrl", CT_NORMAL);
    step(0);
    exp_stall++;
    chk_cnt("mw_done");
    idle();
    @(negedge clk);
    chk_ctrl("mw_back_run", CT_NORMAL);
    step(0);

    // Memory timeout: 15 wait cycles then HALT with mem_err
    mem_req = 1'b1;
    step(0);
    for (int i = 1; i <= 15; i++) begin
      step(0);
      exp_stall++;
      if (i == 14) chk_bit("to_not_yet", halted, 1'b0);
    end
    chk_bit("to_mem_err", mem_err, 1'b1);
    chk_bit("to_halted", halted, 1'b1);
    chk_cnt("to_enter");
    mem_req = 1'b0;
    @(negedge clk);
    chk_ctrl("to_halt_ctrl", CT_FREEZE);
    step(1);
    step(1);
    chk_cnt("to_frozen");
    resume = 1'b1;
    step(1);
    resume = 1'b0;
    chk_bit("to_resume_halted", halted, 1'b0);
    chk_bit("to_resume_err", mem_err, 1'b0);
    @(negedge clk);
    chk_ctrl("to_resume_ctrl", CT_NORMAL);
    step(0);

    // Single wb_halt pulse
    wb_halt = 1'b1;
    @(negedge clk);
    chk_ctrl("halt_retire", CT_HALTGO);
    step(0);
    wb_halt = 1'b0;
    chk_bit("halt_entered", halted, 1'b1);
    step(1);
    step(1);
    chk_cnt("halt_frozen");
    resume = 1'b1;
    step(1);
    resume = 1'b0;
    chk_bit("halt_resumed", halted, 1'b0);

    // wb_halt held across resume must not re-halt until it toggles
    wb_halt = 1'b1;
    step(0);
    chk_bit("held_halted", halted, 1'b1);
    resume = 1'b1;
    step(1);
    resume = 1'b0;
    @(negedge clk);
    chk_ctrl("held_no_rehalt", CT_NORMAL);
    step(0);
    chk_bit("held_still_run", halted, 1'b0);
    wb_halt = 1'b0;
    step(0);
    wb_halt = 1'b1;
    @(negedge clk);
    chk_ctrl("held_rearmed", CT_HALTGO);
    step(0);
    chk_bit("held_rehalted", halted, 1'b1);
    wb_halt = 1'b0;
    resume = 1'b1;
    step(1);
    resume = 1'b0;

    // wb_halt wins over a pending memory stall
    wb_halt = 1'b1;
    mem_req = 1'b1;
    @(negedge clk);
    chk_ctrl("halt_vs_mem", CT_HALTGO);
    step(0);
    idle();
    chk_bit("halt_vs_mem_halted", halted, 1'b1);
    chk_cnt("halt_vs_mem");
    resume = 1'b1;
    step(1);
    resume = 1'b0;

    // Asynchronous reset in the middle of MEM_WAIT
    mem_req = 1'b1;
    step(0);
    step(0);
    exp_stall++;
    chk_cnt("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    exp_stall = '0; exp_flush = '0; exp_cyc = '0;
    chk_cnt("async_rst");
    chk_ctrl("async_rst_ctrl", CT_FREEZE);
    chk_bit("async_rst_halted", halted, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central sequencer for the four inter-stage buffers (IF_ID, ID_EXE, EXE_MEM, MEM_WB) and the PC register of the 5-stage MIPS core.
- Drives every buffer's go/clear pair and the PC enable.
- Resolves load-use stalls, taken-branch flushes, data-memory wait states and syscall halt.
- Keeps saturating stall, flush and cycle counters for the debug display.

Parameters:
CNT_W, 32, width of the stall, flush and cycle counters
MEM_TIMEOUT, 15, maximum consecutive MEM_WAIT cycles before a memory error is flagged (1..255)

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
exe_rd  in  5  destination register of the instruction in EXE
exe_mem_read  in  1  EXE instruction is a load
exe_branch_taken  in  1  EXE resolved a taken branch or jump
mem_req  in  1  MEM-stage instruction accesses data memory
mem_ready  in  1  data memory completes the access this cycle
wb_halt  in  1  syscall-halt instruction is in WB
resume  in  1  restart request from the board (single-cycle pulse)
pc_en  out  1  PC register load enable
go_if_id, clear_if_id  out  1 each  IF_ID buffer controls
go_id_exe, clear_id_exe  out  1 each  ID_EXE buffer controls
go_exe_mem, clear_exe_mem  out  1 each  EXE_MEM buffer controls; clear_exe_mem is constant 0
go_mem_wb, clear_mem_wb  out  1 each  MEM_WB buffer controls
halted  out  1  high while in HALT
mem_err  out  1  sticky memory-timeout flag
stall_cnt, flush_cnt, cycle_cnt  out  CNT_W each  performance counters

Behaviour:
- States: RUN, MEM_WAIT, HALT. State register is 2 bits and reset asynchronously to RUN.
- Reset values:
  - All counters are 0, mem_err is 0, the wait counter is 0.
  - While rst_n is low, every go and pc_en is 0 and every clear is 0.
- Control outputs are combinational from the current state and inputs. Their effect lands at the next rising clk (zero added latency).
- Load-use hazard: load_use = exe_mem_read & exe_rd != 0 & ((id_uses_rs & id_rs == exe_rd) | (id_uses_rt & id_rt == exe_rd)).
- RUN, priority order (highest first):
  1. wb_halt:
     - go_mem_wb = 1 so the halting instruction retires. All other go signals and pc_en are 0.
     - Next state is HALT.
  2. mem_req & !mem_ready:
     - All go signals and pc_en are 0 (full freeze). Next state is MEM_WAIT.
     - The wait counter loads 1.
  3. exe_branch_taken:
     - All go signals are 1 and pc_en = 1. clear_if_id = 1 and clear_id_exe = 1.
     - flush_cnt increments.
     - Branch beats load_use because the ID instruction is on the wrong path.
  4. load_use:
     - pc_en = 0, go_if_id = 0. go_id_exe = 1 with clear_id_exe = 1 to insert a bubble.
     - The remaining go signals are 1. stall_cnt increments.
  5. Otherwise: all go signals are 1, pc_en = 1, all clears are 0.
- MEM_WAIT:
  - Full freeze every cycle. stall_cnt increments every cycle.
  - If mem_ready: apply the RUN decode items 3–5 this same cycle and return to RUN.
  - Else, when the wait counter reaches MEM_TIMEOUT: set mem_err and go to HALT. Otherwise increment the wait counter.
- HALT:
  - All go signals and pc_en are 0.
  - resume returns to RUN on the next edge. mem_err clears on resume.
  - resume in any state other than HALT is ignored.
- cycle_cnt increments every cycle except in HALT.
- All counters saturate at all-ones and never wrap.
- Simultaneous events: wb_halt beats everything, including a pending memory stall. A held wb_halt does not retrigger after resume until it deasserts for at least one cycle; track this with an edge-arming flag.
- rst_n asserted in any state returns immediately to the reset values, even mid-MEM_WAIT.

Decomposition:
- Shared package pipe_pkg:
  - state encoding constants ST_RUN = 2'd0, ST_MEM_WAIT = 2'd1, ST_HALT = 2'd2.
  - REG_ZERO = 5'd0.
  - Bundled go/clear bit order, for reuse by the buffer instances.
- One natural sub-module, hazard_detect: purely combinational load_use compare, reused later by the forwarding unit.

Test Plan:
- Load-use: set exe_mem_read = 1, exe_rd = 8, id_rs = 8, id_uses_rs = 1 for 1 cycle → pc_en = 0, go_if_id = 0, clear_id_exe = 1, stall_cnt 0→1. The next cycle is normal.
- Zero-register case: exe_rd = 0 with the same IDs → no stall, stall_cnt unchanged.
- Branch plus load-use in the same cycle → clear_if_id = 1, clear_id_exe = 1, pc_en = 1, flush_cnt = 1, stall_cnt = 0.
- Memory wait, normal completion: mem_req = 1 with mem_ready low for 3 cycles → full freeze, stall_cnt = 3. Raising mem_ready returns the FSM to RUN that cycle with pc_en = 1.
- Memory wait, timeout: mem_ready never rises → after 15 wait cycles, mem_err = 1 and halted = 1. resume pulse → RUN, mem_err = 0.
- Halt and reset:
  - wb_halt pulse → go_mem_wb = 1 only, then halted = 1 with cycle_cnt frozen.
  - wb_halt held high across resume → no re-halt until it toggles.
  - rst_n low mid-MEM_WAIT → all counters 0 asynchronously.
